// File: rtl/hft_pkg.sv
// hft_pkg
// Shared types and constants for the market-data price path.
//   price_t  : unsigned Q16.16 price word
//   delta_t  : signed difference between two consecutive prices (one guard bit)
//   byte_idx_e : position of the next expected byte inside a price frame
//   timeout_cycles() : converts an inter-byte gap in byte-times into clock cycles
package hft_pkg;

   typedef logic [31:0]        price_t;
   typedef logic signed [32:0] delta_t;

   localparam int FRAME_BYTES        = 4;
   localparam int BITS_PER_BYTE_TIME = 10;

   // IDX_START doubles as "idle": nothing partial is held while here
   typedef enum logic [1:0] {
      IDX_START = 2'd0,
      IDX_1     = 2'd1,
      IDX_2     = 2'd2,
      IDX_LAST  = 2'd3
   } byte_idx_e;

   // 64-bit arithmetic so large clock rates cannot overflow the product
   function automatic longint timeout_cycles(input longint clk_freq,
                                             input longint baud_rate,
                                             input longint gap_bytes);
      return (gap_bytes * BITS_PER_BYTE_TIME * clk_freq) / baud_rate;
   endfunction

endpackage

// File: rtl/price_fifo.sv
// price_fifo
// Two-entry synchronous FIFO with first-word-fall-through output.
//   clk, rst : clock and asynchronous active-high reset
//   push/din : write request and data; ignored when full unless a pop occurs
//              in the same cycle
//   pop      : read request; ignored when empty
//   dout     : oldest entry (valid while !empty)
//   full, empty : occupancy flags
module price_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push, do_pop;

   // A full FIFO can still accept a write when the head leaves in the same
   // cycle: the write pointer then equals the read pointer being released.
   always_comb begin
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != 2'd2) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);

endmodule

// File: rtl/price_frame_assembler.sv
// price_frame_assembler
// Collects 4-byte big-endian UART frames into Q16.16 prices and queues them
// in a 2-entry FIFO for a ready/valid consumer.
//   clk, rst              : clock, asynchronous active-high reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   price_data/valid/ready: output price stream (valid = FIFO not empty)
//   frame_abort           : pulse when a partial frame times out
//   frame_drop            : pulse when a complete frame hits a full FIFO
//   drop_count            : saturating count of dropped frames
// Optional build macro PRICE_DELTA_EN adds price_delta (current minus
// previously queued price) and price_first (no previous price since reset).
module price_frame_assembler
   import hft_pkg::*;
#(
   parameter int CLK_FREQ      = 50_000_000,
   parameter int BAUD_RATE     = 9600,
   parameter int TIMEOUT_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output price_t      price_data,
   output logic        price_valid,
   input  logic        price_ready,
   output logic        frame_abort,
   output logic        frame_drop,
   output logic [15:0] drop_count
`ifdef PRICE_DELTA_EN
   ,
   output delta_t      price_delta,
   output logic        price_first
`endif
);

   localparam longint LIMIT_RAW = timeout_cycles(longint'(CLK_FREQ), longint'(BAUD_RATE),
                                                 longint'(TIMEOUT_BYTES));
   localparam int LIMIT  = (LIMIT_RAW < 64'sd1) ? 1 : int'(LIMIT_RAW);
   // counter only needs to hold 0..LIMIT-1; the LIMIT-th idle cycle is the expiry
   localparam int TMO_W  = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LIMIT - 1);
   localparam int HEAD_W = (FRAME_BYTES - 1) * 8;

`ifdef PRICE_DELTA_EN
   localparam int ENTRY_W = $bits(price_t) + $bits(delta_t) + 1;
`else
   localparam int ENTRY_W = $bits(price_t);
`endif

   byte_idx_e          idx_q, idx_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [HEAD_W-1:0]  head_q, head_d;
   logic               abort_q, abort_d;
   logic               drop_q, drop_d;
   logic [15:0]        drop_count_q, drop_count_d;
   logic               expire, frame_done, pop, accept, drop;
   price_t             frame_word;
   logic [ENTRY_W-1:0] fifo_din, fifo_dout;
   logic               fifo_full, fifo_empty;

   // State register: byte index, timeout counter, frame head and status flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q        <= IDX_START;
         tmo_q        <= '0;
         head_q       <= '0;
         abort_q      <= 1'b0;
         drop_q       <= 1'b0;
         drop_count_q <= '0;
      end else begin
         idx_q        <= idx_d;
         tmo_q        <= tmo_d;
         head_q       <= head_d;
         abort_q      <= abort_d;
         drop_q       <= drop_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Next state: a byte always wins over an expiring timeout in the same cycle
   always_comb begin
      idx_d  = idx_q;
      tmo_d  = tmo_q;
      head_d = head_q;
      if (rx_valid) begin
         tmo_d  = '0;
         head_d = {head_q[HEAD_W-9:0], rx_data};
         case (idx_q)
            IDX_START: idx_d = IDX_1;
            IDX_1:     idx_d = IDX_2;
            IDX_2:     idx_d = IDX_LAST;
            default:   idx_d = IDX_START;
         endcase
      end else if (idx_q != IDX_START) begin
         if (expire) begin
            idx_d = IDX_START;
            tmo_d = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   // Outputs of the collector: expiry, frame completion and FIFO handshakes
   always_comb begin
      expire       = (idx_q != IDX_START) && !rx_valid && (tmo_q == TMO_LAST);
      frame_done   = rx_valid && (idx_q == IDX_LAST);
      frame_word   = {head_q, rx_data};
      pop          = !fifo_empty && price_ready;
      accept       = frame_done && (!fifo_full || pop);
      drop         = frame_done && fifo_full && !pop;
      abort_d      = expire;
      drop_d       = drop;
      drop_count_d = drop_count_q;
      if (drop && (drop_count_q != 16'hFFFF)) begin
         drop_count_d = drop_count_q + 16'd1;
      end
   end

`ifdef PRICE_DELTA_EN
   price_t prev_q, prev_d;
   logic   have_prev_q, have_prev_d;
   delta_t delta_in;

   // Reference price follows only frames that actually enter the FIFO
   always_comb begin
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      delta_in    = have_prev_q ? ($signed({1'b0, frame_word}) - $signed({1'b0, prev_q}))
                                : '0;
      if (accept) begin
         prev_d      = frame_word;
         have_prev_d = 1'b1;
      end
      fifo_din = {frame_word, delta_in, !have_prev_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
      end
   end

   assign {price_data, price_delta, price_first} = fifo_dout;
`else
   assign fifo_din   = frame_word;
   assign price_data = fifo_dout;
`endif

   price_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (frame_done),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign price_valid = !fifo_empty;
   assign frame_abort = abort_q;
   assign frame_drop  = drop_q;
   assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_price_frame_assembler.sv
// tb_price_frame_assembler
// Directed bench for price_frame_assembler. Timeout limit is shrunk to
// 2 byte-times * 10 bits * 1000 Hz / 100 baud = 200 cycles so the gap
// boundary (199 idle cycles accepted, 200 idle cycles abort) is cheap to hit.
// Build with PRICE_DELTA_EN defined to also check the delta outputs.
module tb_price_frame_assembler;
   import hft_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        price_ready = 1'b0;
   price_t      price_data;
   logic        price_valid;
   logic        frame_abort;
   logic        frame_drop;
   logic [15:0] drop_count;
`ifdef PRICE_DELTA_EN
   delta_t      price_delta;
   logic        price_first;
`endif

   int vec_count  = 0;
   int miss_count = 0;
   int abort_seen = 0;
   int drop_seen  = 0;

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      int          gap;
      logic [31:0] expected;
   } vec_t;

   vec_t vecs [6];

   price_frame_assembler #(
      .CLK_FREQ      (1000),
      .BAUD_RATE     (100),
      .TIMEOUT_BYTES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .price_data  (price_data),
      .price_valid (price_valid),
      .price_ready (price_ready),
      .frame_abort (frame_abort),
      .frame_drop  (frame_drop),
      .drop_count  (drop_count)
`ifdef PRICE_DELTA_EN
      ,
      .price_delta (price_delta),
      .price_first (price_first)
`endif
   );

   always #5 clk = ~clk;

   // Count status pulses mid-cycle; a pulse held too long shows up as extra counts
   always @(negedge clk) begin
      if (frame_abort) abort_seen++;
      if (frame_drop)  drop_seen++;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Returns one step after the edge that captured the fourth byte
   task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input int gap);
      sendByte(b0); idle(gap);
      sendByte(b1); idle(gap);
      sendByte(b2); idle(gap);
      sendByte(b3);
   endtask

   initial begin
      int abort_before;
      int drop_before;
`ifdef PRICE_DELTA_EN
      delta_t exp_delta;
`endif

      vecs[0] = '{8'h00, 8'h96, 8'h00, 8'h00,   0, 32'h0096_0000};
      vecs[1] = '{8'h00, 8'h94, 8'h80, 8'h00,   3, 32'h0094_8000};
      vecs[2] = '{8'h00, 8'h93, 8'h00, 8'h00,   1, 32'h0093_0000};
      vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,   0, 32'hFFFF_FFFF};
      vecs[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 199, 32'h1234_5678};
      vecs[5] = '{8'h80, 8'h00, 8'h00, 8'h01, 198, 32'h8000_0001};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset price_valid", 64'(price_valid), 64'd0);
      checkOutput("reset price_data", 64'(price_data), 64'd0);
      checkOutput("reset frame_abort", 64'(frame_abort), 64'd0);
      checkOutput("reset frame_drop", 64'(frame_drop), 64'd0);
      checkOutput("reset drop_count", 64'(drop_count), 64'd0);
      rst = 1'b0;
      idle(2);

      // Table of single frames, consumer always ready
      price_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].gap);
         checkOutput($sformatf("vec%0d price_valid", i), 64'(price_valid), 64'd1);
         checkOutput($sformatf("vec%0d price_data", i), 64'(price_data), 64'(vecs[i].expected));
         idle(1);
         checkOutput($sformatf("vec%0d consumed", i), 64'(price_valid), 64'd0);
      end
      checkOutput("no abort within 199-cycle gaps", 64'(abort_seen), 64'd0);

      // Partial frame times out, then a fresh frame assembles cleanly
      abort_before = abort_seen;
      sendByte(8'h00);
      sendByte(8'h94);
      idle(250);
      checkOutput("timeout abort pulses", 64'(abort_seen - abort_before), 64'd1);
      checkOutput("timeout no price", 64'(price_valid), 64'd0);
      applyStimulus(8'h00, 8'h94, 8'h80, 8'h00, 0);
      checkOutput("post-abort price_data", 64'(price_data), 64'h0094_8000);
      idle(1);

      // Consumer stalled: third frame is dropped, first two drain in order
      price_ready = 1'b0;
      drop_before = drop_seen;
      applyStimulus(8'h00, 8'h96, 8'h00, 8'h00, 0);
      applyStimulus(8'h00, 8'h94, 8'h80, 8'h00, 0);
      applyStimulus(8'h00, 8'h93, 8'h00, 8'h00, 0);
      checkOutput("full drop_count", 64'(drop_count), 64'd1);
      idle(1);
      checkOutput("full drop pulses", 64'(drop_seen - drop_before), 64'd1);
      checkOutput("stalled price_data stable", 64'(price_data), 64'h0096_0000);
      price_ready = 1'b1;
      checkOutput("drain first", 64'(price_data), 64'h0096_0000);
      idle(1);
      checkOutput("drain second", 64'(price_data), 64'h0094_8000);
      idle(1);
      checkOutput("drain empty", 64'(price_valid), 64'd0);

      // Full FIFO with a pop in the 4th-byte cycle accepts the new frame
      price_ready = 1'b0;
      drop_before = drop_seen;
      applyStimulus(8'h00, 8'h96, 8'h00, 8'h00, 0);
      applyStimulus(8'h00, 8'h94, 8'h80, 8'h00, 0);
      sendByte(8'h00);
      sendByte(8'h93);
      sendByte(8'h00);
      rx_data     = 8'h00;
      rx_valid    = 1'b1;
      price_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      checkOutput("push+pop no drop pulse", 64'(frame_drop), 64'd0);
      checkOutput("push+pop drop_count", 64'(drop_count), 64'd1);
      checkOutput("push+pop head", 64'(price_data), 64'h0094_8000);
      idle(1);
      checkOutput("push+pop newest last", 64'(price_data), 64'h0093_0000);
      idle(1);
      checkOutput("push+pop empty", 64'(price_valid), 64'd0);
      checkOutput("push+pop no drop seen", 64'(drop_seen - drop_before), 64'd0);

      // Asynchronous reset mid-frame with a price still queued
      price_ready = 1'b0;
      applyStimulus(8'h00, 8'h96, 8'h00, 8'h00, 0);
      sendByte(8'h00);
      sendByte(8'h94);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async rst price_valid", 64'(price_valid), 64'd0);
      checkOutput("async rst price_data", 64'(price_data), 64'd0);
      checkOutput("async rst drop_count", 64'(drop_count), 64'd0);
      checkOutput("async rst frame_drop", 64'(frame_drop), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      price_ready = 1'b1;
      idle(1);
      applyStimulus(8'h00, 8'h96, 8'h00, 8'h00, 0);
      checkOutput("post-rst price_valid", 64'(price_valid), 64'd1);
      checkOutput("post-rst price_data", 64'(price_data), 64'h0096_0000);
`ifdef PRICE_DELTA_EN
      checkOutput("delta first flag", 64'(price_first), 64'd1);
      checkOutput("delta first value", 64'(price_delta), 64'd0);
`endif
      idle(1);
      applyStimulus(8'h00, 8'h94, 8'h80, 8'h00, 0);
      checkOutput("second price_data", 64'(price_data), 64'h0094_8000);
`ifdef PRICE_DELTA_EN
      exp_delta = -33'sd98304;
      checkOutput("delta second flag", 64'(price_first), 64'd0);
      checkOutput("delta second value", {31'd0, price_delta}, {31'd0, exp_delta});
`endif
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule

// File: doc/price_frame_assembler.md
PRICE_FRAME_ASSEMBLER -- requirements
Module: price_frame_assembler

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, UART line rate used for timeout derivation.
REQ-003 Parameter TIMEOUT_BYTES, default 4, inter-byte gap in byte-times (10 bits each) that aborts a partial frame.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rx_data  in  8  received UART byte.
REQ-007 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-008 price_data  out  32  assembled price, unsigned Q16.16.
REQ-009 price_valid  out  1  price_data holds an unconsumed price.
REQ-010 price_ready  in  1  downstream (RSI engine) accepts price this cycle.
REQ-011 frame_abort  out  1  one-cycle pulse: partial frame discarded on timeout.
REQ-012 frame_drop  out  1  one-cycle pulse: complete frame discarded, buffer full.
REQ-013 drop_count  out  16  saturating count of frame_drop events.

Function
REQ-014 Frame = 4 bytes, big-endian (first byte -> price[31:24]); byte index counter 0..3.
REQ-015 States: COLLECT (index 0..3 tracked), no separate idle; index 0 = waiting for frame start.
REQ-016 On rx_valid with index 3: frame complete, pushed to a 2-entry FIFO, index -> 0.
REQ-017 Latency: price_valid high the cycle after the 4th rx_valid when FIFO empty.
REQ-018 Transfer occurs on price_valid && price_ready; price_data stable while price_valid && !price_ready.
REQ-019 FIFO strictly in order; price_valid = FIFO not empty.
REQ-020 Push while full with no simultaneous pop: frame discarded, frame_drop pulses, drop_count += 1, saturating at 0xFFFF.
REQ-021 Push while full with simultaneous pop: push accepted, no drop.
REQ-022 Timeout counter clears on every rx_valid, counts only while index != 0; limit TIMEOUT_BYTES*10*CLK_FREQ/BAUD_RATE cycles.
REQ-023 On reaching limit: index -> 0, partial bytes discarded, frame_abort pulses one cycle, counter clears.
REQ-024 rx_valid in the expiry cycle takes priority: byte accepted at current index, no abort.

Reset
REQ-025 rst asserted: index=0, timeout counter=0, FIFO emptied, price_data=0, price_valid=0, frame_abort=0, frame_drop=0, drop_count=0, delta outputs 0, immediately and asynchronously.
REQ-026 Reset mid-frame discards partial bytes; first rx_valid after deassertion is byte 0.

Configuration
REQ-027 Macro PRICE_DELTA_EN; when defined, adds outputs price_delta (33, signed) and price_first (1).
REQ-028 With PRICE_DELTA_EN: delta = {0,current} - {0,previous pushed price}, computed at push, stored in FIFO alongside price; price_first=1 and delta=0 for first push after reset; dropped frames do not update previous.
REQ-029 Without PRICE_DELTA_EN: ports absent, no delta storage or subtractor.

Structure
REQ-030 Package hft_pkg holds price_t (32-bit Q16.16), delta_t (33-bit signed), FRAME_BYTES=4, BITS_PER_BYTE_TIME=10.
REQ-031 Sub-module price_fifo: 2-entry synchronous FIFO, parameterised width, push/pop/full/empty.

Verification
REQ-032 Bytes 00 96 00 00, price_ready=1 -> price_valid one cycle after 4th byte, price_data=0x00960000 (150.00), consumed.
REQ-033 Bytes 00 94, gap > timeout -> one frame_abort pulse; then 00 94 80 00 -> price_data=0x00948000 (148.50).
REQ-034 price_ready=0, three frames 150.00/148.50/147.00 -> third frame_drop, drop_count=1; release ready -> 0x00960000 then 0x00948000.
REQ-035 FIFO full, price_ready=1 in cycle of 4th byte -> no frame_drop, new price delivered last.
REQ-036 rst pulsed after 2 bytes -> all outputs 0; next 00 96 00 00 -> 0x00960000.
REQ-037 PRICE_DELTA_EN: 150.00 then 148.50 -> first: price_first=1, delta 0; second: price_first=0, delta=-98304 (-0x18000).
